// File: rtl/trace_sequencer_if.sv
// Bus between the row controller, the wall tracer and the row renderer.
// The controller uses the slave modport; the driving environment uses the master modport.
interface trace_sequencer_if #(
  parameter int unsigned W     = 24,
  parameter int unsigned SIZEW = 11
);
  localparam int unsigned ROWW = 10;

  // frame / line timing and camera plane
  logic                 vsync;
  logic                 i_line;
  logic signed [W-1:0]  i_vplaneX;
  logic signed [W-1:0]  i_vplaneY;

  // tracer result handshake
  logic                 i_done;
  logic                 i_side;
  logic [SIZEW-1:0]     i_size;

  // tracer control and renderer presentation
  logic                 o_run;
  logic [ROWW-1:0]      o_trace_row;
  logic signed [W-1:0]  o_addendX;
  logic signed [W-1:0]  o_addendY;
  logic                 o_side;
  logic [SIZEW-1:0]     o_size;
  logic                 o_valid;
  logic                 o_overrun;

  modport master (
    output vsync, i_line, i_vplaneX, i_vplaneY, i_done, i_side, i_size,
    input  o_run, o_trace_row, o_addendX, o_addendY, o_side, o_size, o_valid, o_overrun
  );

  modport slave (
    input  vsync, i_line, i_vplaneX, i_vplaneY, i_done, i_side, i_size,
    output o_run, o_trace_row, o_addendX, o_addendY, o_side, o_size, o_valid, o_overrun
  );
endinterface

// File: rtl/trace_sequencer.sv
// Row-level controller for the wall tracer: preloads the ray-deflection accumulator per frame,
// gates the tracer row by row and presents each finished result on the following line strobe.
module trace_sequencer #(
  parameter int unsigned ROWS  = 480,
  parameter int unsigned W     = 24,
  parameter int unsigned SIZEW = 11
) (
  input logic              clk,
  input logic              reset,
  trace_sequencer_if.slave bus
);

  localparam int unsigned ROWW = 10;
  localparam int unsigned HALF = ROWS / 2;
  localparam logic [ROWW-1:0] HALF_CNT = ROWW'(HALF);
  localparam logic [ROWW-1:0] LAST_ROW = ROWW'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    RESTART,
    TRACE,
    DONE
  } state_t;

  state_t              state;
  logic [ROWW-1:0]     cnt;
  logic signed [W-1:0] vplaneX;
  logic signed [W-1:0] vplaneY;
  logic signed [W-1:0] addendX;
  logic signed [W-1:0] addendY;
  logic [ROWW-1:0]     traceRow;
  logic                run;
  logic                resOk;
  logic                resSide;
  logic [SIZEW-1:0]    resSize;
  logic                side;
  logic [SIZEW-1:0]    size;
  logic                valid;
  logic                overrun;

  // A result finishing in the strobe cycle itself still counts as on time.
  logic             captureNow;
  logic             presentOk;
  logic             presentSide;
  logic [SIZEW-1:0] presentSize;

  assign captureNow  = (state == TRACE) && bus.i_done;
  assign presentOk   = resOk || captureNow;
  assign presentSide = captureNow ? bus.i_side : resSide;
  assign presentSize = captureNow ? bus.i_size : resSize;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      vplaneX  <= '0;
      vplaneY  <= '0;
      addendX  <= '0;
      addendY  <= '0;
      traceRow <= '0;
      run      <= 1'b0;
      resOk    <= 1'b0;
      resSide  <= 1'b0;
      resSize  <= '0;
      side     <= 1'b0;
      size     <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else if (bus.vsync) begin
      // Vertical blank restarts the frame and tracks the camera plane until it ends.
      state    <= PRELOAD;
      cnt      <= '0;
      vplaneX  <= bus.i_vplaneX;
      vplaneY  <= bus.i_vplaneY;
      addendX  <= '0;
      addendY  <= '0;
      traceRow <= '0;
      run      <= 1'b0;
      overrun  <= 1'b0;
      resOk    <= 1'b0;
    end else begin
      case (state)
        PRELOAD: begin
          if (bus.i_line) begin
            overrun <= 1'b1;
          end
          if (cnt == HALF_CNT) begin
            state <= TRACE;
            run   <= 1'b1;
          end else begin
            addendX <= addendX - vplaneX;
            addendY <= addendY - vplaneY;
            cnt     <= cnt + ROWW'(1);
          end
        end

        RESTART, TRACE, DONE: begin
          if (state == RESTART) begin
            state <= TRACE;
            run   <= 1'b1;
          end
          if (captureNow) begin
            resSide <= bus.i_side;
            resSize <= bus.i_size;
            resOk   <= 1'b1;
            state   <= DONE;
          end
          // Line strobe: present the previous row and move the tracer on; overrides the above.
          if (bus.i_line) begin
            side  <= presentOk && presentSide;
            size  <= presentOk ? presentSize : '0;
            valid <= presentOk;
            if ((state == TRACE) && !bus.i_done) begin
              overrun <= 1'b1;
            end
            run <= 1'b0;
            if (traceRow == LAST_ROW) begin
              state <= IDLE;
            end else begin
              traceRow <= traceRow + ROWW'(1);
              addendX  <= addendX + vplaneX;
              addendY  <= addendY + vplaneY;
              resOk    <= 1'b0;
              state    <= RESTART;
            end
          end
        end

        default: begin
          run <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_run       = run;
  assign bus.o_trace_row = traceRow;
  assign bus.o_addendX   = addendX;
  assign bus.o_addendY   = addendY;
  assign bus.o_side      = side;
  assign bus.o_size      = size;
  assign bus.o_valid     = valid;
  assign bus.o_overrun   = overrun;

endmodule

// File: tb/tb_trace_sequencer.sv
// Self-checking bench for trace_sequencer: frame-level reference model (addend = vplane*(r-ROWS/2),
// result shown on the strobe ending its trace) driven with directed and randomized row timing.
module tb_trace_sequencer;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned W     = 24;
  localparam int unsigned SIZEW = 11;
  localparam int          HALF  = int'(ROWS / 2);

  logic clk = 1'b0;
  logic reset;
  int   nCompared   = 0;
  int   nMismatched = 0;

  // Per-row stimulus plan: done offset (-1 = withheld) and strobe offset from the run rise.
  int               dArr    [ROWS];
  int               lArr    [ROWS];
  logic [SIZEW-1:0] sizeArr [ROWS];
  logic             sideArr [ROWS];

  trace_sequencer_if #(.W(W), .SIZEW(SIZEW)) bus ();

  trace_sequencer #(.ROWS(ROWS), .W(W), .SIZEW(SIZEW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [W-1:0] expAddend(input logic signed [W-1:0] v, input int row);
    longint p;
    p = longint'(v) * longint'(row - HALF);
    return W'(p);
  endfunction

  // Runs one frame from vsync; abortRow >= 0 reasserts vsync three cycles into that row.
  task automatic play_frame(input logic signed [W-1:0] vx, input logic signed [W-1:0] vy,
                            input bit lineInPreload, input int abortRow);
    int               k;
    bit               ovr;
    bit               comp;
    bit               runDrop;
    logic [SIZEW-1:0] eSize;
    logic             eSide;
    eSize = '0;
    eSide = 1'b0;
    comp  = 1'b0;
    bus.vsync = 1'b1; bus.i_vplaneX = vx; bus.i_vplaneY = vy;
    bus.i_line = 1'b0; bus.i_done = 1'b0;
    tick; tick;
    nCompared++;
    if (bus.o_run !== 1'b0 || bus.o_overrun !== 1'b0 || bus.o_trace_row !== 10'd0) begin
      nMismatched++;
      $display("FAIL vsync_clear: run=%b overrun=%b row=%0d, required 0/0/0",
               bus.o_run, bus.o_overrun, bus.o_trace_row);
    end
    bus.vsync = 1'b0;
    bus.i_vplaneX = W'($urandom);
    bus.i_vplaneY = W'($urandom);
    k = 0;
    while (bus.o_run !== 1'b1 && k < 4 * int'(ROWS) + 8) begin
      bus.i_line = lineInPreload && (k == 1);
      tick;
      k++;
    end
    bus.i_line = 1'b0;
    nCompared++;
    if (k != HALF + 1) begin
      nMismatched++;
      $display("FAIL run_rise: took %0d cycles, required %0d", k, HALF + 1);
    end
    ovr = lineInPreload;
    for (int r = 0; r < int'(ROWS); r++) begin
      nCompared++;
      if (bus.o_trace_row !== 10'(r) || bus.o_addendX !== expAddend(vx, r) ||
          bus.o_addendY !== expAddend(vy, r) || bus.o_overrun !== ovr) begin
        nMismatched++;
        $display("FAIL row%0d_start: row=%0d X=%h Y=%h ovr=%b, required row=%0d X=%h Y=%h ovr=%b",
                 r, bus.o_trace_row, bus.o_addendX, bus.o_addendY, bus.o_overrun,
                 r, expAddend(vx, r), expAddend(vy, r), ovr);
      end
      runDrop = 1'b0;
      for (int c = 0; c <= lArr[r]; c++) begin
        if (abortRow == r && c == 3) begin
          bus.vsync = 1'b1; bus.i_done = 1'b0; bus.i_line = 1'b0;
          tick;
          nCompared++;
          if (bus.o_run !== 1'b0 || bus.o_overrun !== 1'b0 || bus.o_trace_row !== 10'd0) begin
            nMismatched++;
            $display("FAIL abort_vsync: run=%b overrun=%b row=%0d, required 0/0/0",
                     bus.o_run, bus.o_overrun, bus.o_trace_row);
          end
          return;
        end
        bus.i_done = (c == dArr[r]);
        bus.i_size = (c == dArr[r]) ? sizeArr[r] : SIZEW'($urandom);
        bus.i_side = (c == dArr[r]) ? sideArr[r] : 1'($urandom);
        bus.i_line = (c == lArr[r]);
        tick;
        if (c < lArr[r] && bus.o_run !== 1'b1) runDrop = 1'b1;
      end
      bus.i_done = 1'b0;
      bus.i_line = 1'b0;
      comp = (dArr[r] >= 0) && (dArr[r] <= lArr[r]);
      if (!comp) ovr = 1'b1;
      eSize = comp ? sizeArr[r] : '0;
      eSide = comp ? sideArr[r] : 1'b0;
      nCompared++;
      if (runDrop) begin
        nMismatched++;
        $display("FAIL row%0d_run_held: run dropped during trace, required 1", r);
      end
      nCompared++;
      if (bus.o_valid !== comp || bus.o_size !== eSize || bus.o_side !== eSide) begin
        nMismatched++;
        $display("FAIL row%0d_display: valid=%b size=%h side=%b, required valid=%b size=%h side=%b",
                 r, bus.o_valid, bus.o_size, bus.o_side, comp, eSize, eSide);
      end
      nCompared++;
      if (bus.o_overrun !== ovr || bus.o_run !== 1'b0) begin
        nMismatched++;
        $display("FAIL row%0d_line_status: overrun=%b run=%b, required overrun=%b run=0",
                 r, bus.o_overrun, bus.o_run, ovr);
      end
      if (r < int'(ROWS) - 1) begin
        nCompared++;
        if (bus.o_trace_row !== 10'(r + 1) || bus.o_addendX !== expAddend(vx, r + 1)) begin
          nMismatched++;
          $display("FAIL row%0d_advance: row=%0d X=%h, required row=%0d X=%h",
                   r, bus.o_trace_row, bus.o_addendX, r + 1, expAddend(vx, r + 1));
        end
        tick;
        nCompared++;
        if (bus.o_run !== 1'b1) begin
          nMismatched++;
          $display("FAIL row%0d_run_restart: run=%b, required 1", r, bus.o_run);
        end
      end
    end
    // End of frame: idle, strobes and done ignored, last result held.
    runDrop = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.i_line = (c == 2);
      bus.i_done = (c == 1);
      bus.i_size = SIZEW'($urandom);
      tick;
      if (bus.o_run !== 1'b0) runDrop = 1'b1;
    end
    bus.i_line = 1'b0;
    bus.i_done = 1'b0;
    nCompared++;
    if (runDrop || bus.o_size !== eSize || bus.o_side !== eSide || bus.o_valid !== comp ||
        bus.o_trace_row !== 10'(ROWS - 1)) begin
      nMismatched++;
      $display("FAIL idle_hold: run_seen=%b size=%h side=%b valid=%b row=%0d, required 0 %h %b %b %0d",
               runDrop, bus.o_size, bus.o_side, bus.o_valid, bus.o_trace_row,
               eSize, eSide, comp, ROWS - 1);
    end
  endtask

  task automatic plan_normal();
    for (int r = 0; r < int'(ROWS); r++) begin
      lArr[r]    = 38;
      dArr[r]    = 10;
      sizeArr[r] = SIZEW'(32'h123 + 32'(r));
      sideArr[r] = 1'(r);
    end
  endtask

  task automatic test_reset();
    nCompared++;
    if (bus.o_run !== 1'b0 || bus.o_trace_row !== 10'd0 || bus.o_addendX !== '0 ||
        bus.o_addendY !== '0 || bus.o_side !== 1'b0 || bus.o_size !== '0 ||
        bus.o_valid !== 1'b0 || bus.o_overrun !== 1'b0) begin
      nMismatched++;
      $display("FAIL reset_values: run=%b row=%0d X=%h Y=%h side=%b size=%h valid=%b ovr=%b, required all 0",
               bus.o_run, bus.o_trace_row, bus.o_addendX, bus.o_addendY, bus.o_side,
               bus.o_size, bus.o_valid, bus.o_overrun);
    end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.i_line = (c == 2);
      tick;
    end
    bus.i_line = 1'b0;
    nCompared++;
    if (bus.o_run !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_trace_row !== 10'd0) begin
      nMismatched++;
      $display("FAIL reset_idle: run=%b valid=%b row=%0d, required 0/0/0",
               bus.o_run, bus.o_valid, bus.o_trace_row);
    end
  endtask

  task automatic test_normal_frame();
    plan_normal();
    play_frame(W'(32'sh100), W'(-32'sh80), 1'b0, -1);
  endtask

  task automatic test_overrun();
    plan_normal();
    dArr[3] = -1;
    play_frame(W'(32'sh100), W'(-32'sh80), 1'b0, -1);
  endtask

  task automatic test_same_cycle();
    plan_normal();
    for (int r = 0; r < int'(ROWS); r++) dArr[r] = lArr[r];
    play_frame(W'(32'sh2a5), W'(32'sh1f0), 1'b0, -1);
  endtask

  task automatic test_preload_line_abort();
    plan_normal();
    play_frame(W'(32'sh100), W'(-32'sh80), 1'b1, 5);
    play_frame(W'(32'sh100), W'(-32'sh80), 1'b0, -1);
  endtask

  task automatic test_async_reset();
    int  k;
    bit  runSeen;
    bus.vsync = 1'b1; bus.i_vplaneX = W'(32'sh100); bus.i_vplaneY = W'(-32'sh80);
    tick; tick;
    bus.vsync = 1'b0;
    k = 0;
    while (bus.o_run !== 1'b1 && k < 50) begin
      tick;
      k++;
    end
    tick; tick; tick;
    #3 reset = 1'b1;
    #1;
    nCompared++;
    if (bus.o_run !== 1'b0 || bus.o_trace_row !== 10'd0 || bus.o_addendX !== '0 ||
        bus.o_addendY !== '0 || bus.o_side !== 1'b0 || bus.o_size !== '0 ||
        bus.o_valid !== 1'b0 || bus.o_overrun !== 1'b0) begin
      nMismatched++;
      $display("FAIL async_reset: run=%b row=%0d X=%h Y=%h side=%b size=%h valid=%b ovr=%b, required all 0",
               bus.o_run, bus.o_trace_row, bus.o_addendX, bus.o_addendY, bus.o_side,
               bus.o_size, bus.o_valid, bus.o_overrun);
    end
    tick;
    reset = 1'b0;
    runSeen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      bus.i_line = (c % 8 == 7);
      bus.i_done = 1'($urandom);
      tick;
      if (bus.o_run !== 1'b0) runSeen = 1'b1;
    end
    bus.i_line = 1'b0;
    bus.i_done = 1'b0;
    nCompared++;
    if (runSeen) begin
      nMismatched++;
      $display("FAIL reset_stays_idle: run seen high before vsync, required 0");
    end
    plan_normal();
    play_frame(W'(32'sh100), W'(-32'sh80), 1'b0, -1);
  endtask

  task automatic test_random();
    int sel;
    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        lArr[r]    = int'($urandom_range(20, 3));
        sel        = int'($urandom_range(4, 0));
        dArr[r]    = (sel == 0) ? -1 : (sel == 1) ? lArr[r] : int'($urandom % 32'(lArr[r]));
        sizeArr[r] = SIZEW'($urandom);
        sideArr[r] = 1'($urandom);
      end
      play_frame(W'($urandom), W'($urandom), 1'($urandom), -1);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.vsync = 1'b0; bus.i_line = 1'b0; bus.i_done = 1'b0;
    bus.i_side = 1'b0; bus.i_size = '0;
    bus.i_vplaneX = '0; bus.i_vplaneY = '0;
    tick; tick;
    test_reset();
    test_normal_frame();
    test_async_reset();
    test_overrun();
    test_same_cycle();
    test_preload_line_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
